// File: rtl/jk_pkg.sv
// jk_pkg: shared constants and types for the JK flip-flop counter family
//   MODE_*   : counter operating modes carried on a jk_mode_t
//   JK_*     : {j,k} action encodings understood by jk_ff_cell
package jk_pkg;
    typedef logic [1:0] jk_mode_t;
    localparam jk_mode_t MODE_HOLD = 2'b00;
    localparam jk_mode_t MODE_UP   = 2'b01;
    localparam jk_mode_t MODE_DOWN = 2'b10;
    localparam jk_mode_t MODE_LOAD = 2'b11;
    localparam logic [1:0] JK_HOLD   = 2'b00;
    localparam logic [1:0] JK_RESET  = 2'b01;
    localparam logic [1:0] JK_SET    = 2'b10;
    localparam logic [1:0] JK_TOGGLE = 2'b11;
endpackage

// File: rtl/jk_ff_cell.sv
// jk_ff_cell: one-bit JK flip-flop with asynchronous active-high reset
//   clk, rst : clock and async reset (q cleared)
//   j, k     : JK controls (hold / reset / set / toggle)
//   q, nq    : stored bit and its complement
module jk_ff_cell
    import jk_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic j,
    input  logic k,
    output logic q,
    output logic nq
);
    always_ff @(posedge clk or posedge rst)
        if (rst)
            q <= 1'b0;
        else
            q <= ({j, k} == JK_SET)    ? 1'b1 :
                 ({j, k} == JK_RESET)  ? 1'b0 :
                 ({j, k} == JK_TOGGLE) ? ~q   : q;
    assign nq = ~q;
endmodule

// File: rtl/jk_sync_counter.sv
// jk_sync_counter: modulo-MODULUS up/down/load counter built from JK cells
//   clk, rst  : clock and async active-high reset
//   en, mode  : enable and operation (hold/up/down/load)
//   load_val  : parallel load value, clamped to MODULUS-1
//   q, nq     : count and its complement
//   tc        : combinational terminal count for cascading
//   wrap      : registered pulse after a wrap-around
//   load_err  : registered pulse after a clamped load
module jk_sync_counter
    import jk_pkg::*;
#(
    parameter int WIDTH   = 4,
    parameter int MODULUS = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  jk_mode_t         mode,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] nq,
    output logic             tc,
    output logic             wrap,
    output logic             load_err
);
    localparam logic [WIDTH-1:0] MAX   = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH:0]   MOD_W = (WIDTH + 1)'(MODULUS);
    generate
        if (WIDTH < 1 || MODULUS < 2 || MODULUS > 2 ** WIDTH) begin : g_bad_params
            $error("jk_sync_counter: need WIDTH >= 1 and 2 <= MODULUS <= 2**WIDTH");
        end
    endgenerate
    logic             at_max, at_zero, clamp;
    logic [WIDTH-1:0] target, j, k;
    always_comb begin
        at_max  = q == MAX;
        at_zero = q == '0;
        // compared one bit wider so MODULUS = 2**WIDTH is representable
        clamp   = {1'b0, load_val} >= MOD_W;
        target  = (mode == MODE_UP)   ? (at_max  ? '0  : q + 1'b1) :
                  (mode == MODE_DOWN) ? (at_zero ? MAX : q - 1'b1) :
                  (clamp ? MAX : load_val);
        // counting toggles exactly the bits that differ; loading sets/resets each bit
        j  = (!en || mode == MODE_HOLD) ? '0 : (mode == MODE_LOAD) ? target  : q ^ target;
        k  = (!en || mode == MODE_HOLD) ? '0 : (mode == MODE_LOAD) ? ~target : q ^ target;
        tc = en && ((mode == MODE_UP && at_max) || (mode == MODE_DOWN && at_zero));
    end
    genvar i;
    generate
        for (i = 0; i < WIDTH; i++) begin : g_cell
            jk_ff_cell u_cell (
                .clk (clk),
                .rst (rst),
                .j   (j[i]),
                .k   (k[i]),
                .q   (q[i]),
                .nq  (nq[i])
            );
        end
    endgenerate
    // a wrap-around happens exactly on an edge where terminal count is asserted
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            wrap     <= 1'b0;
            load_err <= 1'b0;
        end else begin
            wrap     <= tc;
            load_err <= en && mode == MODE_LOAD && clamp;
        end
endmodule

// File: tb/tb_jk_sync_counter.sv
// tb_jk_sync_counter: directed and random checks of jk_sync_counter against an arithmetic model
module tb_jk_sync_counter;
    import jk_pkg::*;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;
    logic en_a, en_b, en_c;
    jk_mode_t mode_a, mode_b, mode_c;
    logic [3:0] lv_a, lv_c;
    logic [2:0] lv_b;
    logic [3:0] q_a, nq_a, q_lo, nq_lo, q_hi, nq_hi;
    logic [2:0] q_b, nq_b;
    logic tc_a, wrap_a, err_a, tc_b, wrap_b, err_b;
    logic tc_lo, wrap_lo, err_lo, tc_hi, wrap_hi, err_hi;
    jk_sync_counter #(.WIDTH(4), .MODULUS(10)) dut_a (
        .clk(clk), .rst(rst), .en(en_a), .mode(mode_a), .load_val(lv_a),
        .q(q_a), .nq(nq_a), .tc(tc_a), .wrap(wrap_a), .load_err(err_a));
    jk_sync_counter #(.WIDTH(3), .MODULUS(8)) dut_b (
        .clk(clk), .rst(rst), .en(en_b), .mode(mode_b), .load_val(lv_b),
        .q(q_b), .nq(nq_b), .tc(tc_b), .wrap(wrap_b), .load_err(err_b));
    jk_sync_counter #(.WIDTH(4), .MODULUS(10)) dut_lo (
        .clk(clk), .rst(rst), .en(en_c), .mode(mode_c), .load_val(lv_c),
        .q(q_lo), .nq(nq_lo), .tc(tc_lo), .wrap(wrap_lo), .load_err(err_lo));
    jk_sync_counter #(.WIDTH(4), .MODULUS(10)) dut_hi (
        .clk(clk), .rst(rst), .en(tc_lo), .mode(mode_c), .load_val(lv_c),
        .q(q_hi), .nq(nq_hi), .tc(tc_hi), .wrap(wrap_hi), .load_err(err_hi));
    int n_asserts = 0;
    int n_fails = 0;
    int md[4] = '{10, 8, 10, 10};
    int wd[4] = '{4, 3, 4, 4};
    int mq[4];
    bit mwr[4], mer[4];
    task automatic chk(input string tag, input int obs, input int exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask
    function automatic bit term(input int mod, input int q, input bit en, input int mode);
        return en && ((mode == 1 && q == mod - 1) || (mode == 2 && q == 0));
    endfunction
    function automatic int nxt(input int mod, input int q, input bit en, input int mode, input int lv);
        if (!en) return q;
        case (mode)
            1: return (q + 1) % mod;
            2: return (q + mod - 1) % mod;
            3: return (lv >= mod) ? mod - 1 : lv;
            default: return q;
        endcase
    endfunction
    task automatic chk_state();
        int oq[4], onq[4], ow[4], oe[4];
        oq  = '{int'(q_a), int'(q_b), int'(q_lo), int'(q_hi)};
        onq = '{int'(nq_a), int'(nq_b), int'(nq_lo), int'(nq_hi)};
        ow  = '{int'(wrap_a), int'(wrap_b), int'(wrap_lo), int'(wrap_hi)};
        oe  = '{int'(err_a), int'(err_b), int'(err_lo), int'(err_hi)};
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("q[%0d]", i), oq[i], mq[i]);
            chk($sformatf("nq[%0d]", i), onq[i], (~mq[i]) & ((1 << wd[i]) - 1));
            chk($sformatf("wrap[%0d]", i), ow[i], int'(mwr[i]));
            chk($sformatf("load_err[%0d]", i), oe[i], int'(mer[i]));
        end
    endtask
    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            mq[i] = 0;
            mwr[i] = 1'b0;
            mer[i] = 1'b0;
        end
    endtask
    task automatic tick();
        bit e[4];
        int m[4], l[4], ot[4];
        #1;
        e  = '{en_a, en_b, en_c, term(10, mq[2], en_c, int'(mode_c))};
        m  = '{int'(mode_a), int'(mode_b), int'(mode_c), int'(mode_c)};
        l  = '{int'(lv_a), int'(lv_b), int'(lv_c), int'(lv_c)};
        ot = '{int'(tc_a), int'(tc_b), int'(tc_lo), int'(tc_hi)};
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("tc[%0d]", i), ot[i], int'(term(md[i], mq[i], e[i], m[i])));
            mwr[i] = term(md[i], mq[i], e[i], m[i]);
            mer[i] = e[i] && m[i] == 3 && l[i] >= md[i];
            mq[i]  = nxt(md[i], mq[i], e[i], m[i], l[i]);
        end
        @(posedge clk);
        #1;
        chk_state();
    endtask
    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask
    initial begin
        en_a = 1'b0; en_b = 1'b0; en_c = 1'b0;
        mode_a = MODE_HOLD; mode_b = MODE_HOLD; mode_c = MODE_UP;
        lv_a = '0; lv_b = '0; lv_c = '0;
        model_reset();
        #2;
        chk_state();
        rst = 1'b0;
        en_a = 1'b1; mode_a = MODE_UP;
        ticks(4);
        #2 rst = 1'b1;
        #1;
        model_reset();
        chk_state();
        chk("mid_reset_q", int'(q_a), 0);
        rst = 1'b0;
        ticks(12);
        chk("up12_q", int'(q_a), 2);
        mode_a = MODE_DOWN;
        ticks(4);
        chk("down_q", int'(q_a), 8);
        mode_a = MODE_LOAD; lv_a = 4'd7;
        tick();
        chk("load7_q", int'(q_a), 7);
        lv_a = 4'd12;
        tick();
        chk("load12_q", int'(q_a), 9);
        chk("load12_err", int'(err_a), 1);
        lv_a = 4'd5;
        tick();
        mode_a = MODE_HOLD;
        ticks(3);
        en_a = 1'b0; mode_a = MODE_UP;
        ticks(3);
        chk("hold_q", int'(q_a), 5);
        chk("hold_nq", int'(nq_a), 10);
        chk("hold_tc", int'(tc_a), 0);
        en_b = 1'b1; mode_b = MODE_LOAD; lv_b = 3'd6;
        tick();
        mode_b = MODE_UP;
        ticks(3);
        chk("pow2_q", int'(q_b), 1);
        en_b = 1'b0;
        chk("casc_start", int'(q_lo) + int'(q_hi), 0);
        en_c = 1'b1; mode_c = MODE_UP;
        ticks(25);
        chk("casc_lo", int'(q_lo), 5);
        chk("casc_hi", int'(q_hi), 2);
        for (int n = 0; n < 300; n++) begin
            en_a = $urandom_range(0, 3) != 0;
            mode_a = jk_mode_t'($urandom_range(0, 3));
            lv_a = 4'($urandom_range(0, 15));
            en_b = $urandom_range(0, 3) != 0;
            mode_b = jk_mode_t'($urandom_range(0, 3));
            lv_b = 3'($urandom_range(0, 7));
            en_c = $urandom_range(0, 3) != 0;
            mode_c = jk_mode_t'($urandom_range(0, 3));
            lv_c = 4'($urandom_range(0, 15));
            tick();
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
        $finish;
    end
endmodule
